rgb_cmd_ctrl: RTL and testbench

RGB_CMD_CTRL -- requirements
Module: rgb_cmd_ctrl

---
 rtl/rgb_cmd_pkg.sv | 41 ++++
 rtl/byte_fifo.sv | 55 +++++
 rtl/rgb_cmd_ctrl.sv | 129 ++++++++++++
 tb/tb_rgb_cmd_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rgb_cmd_pkg.sv
// Shared constants and encodings for the RGB LED command parser.
// Command bytes, parser states and LED color selects live here.
package rgb_cmd_pkg;

    localparam logic [7:0] CMD_RED   = 8'h72;
    localparam logic [7:0] CMD_GREEN = 8'h67;
    localparam logic [7:0] CMD_BLUE  = 8'h62;
    localparam logic [7:0] CMD_OFF   = 8'h6F;
    localparam logic [7:0] CMD_INT   = 8'h69;

    localparam logic [7:0] DUTY_RESET = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DECODE   = 2'd1,
        ST_ARG_WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        COL_OFF = 2'd0,
        COL_R   = 2'd1,
        COL_G   = 2'd2,
        COL_B   = 2'd3
    } color_t;

    function automatic logic is_color_cmd(input logic [7:0] b);
        return (b == CMD_RED) || (b == CMD_GREEN) || (b == CMD_BLUE) || (b == CMD_OFF);
    endfunction

    function automatic color_t cmd_color(input logic [7:0] b);
        color_t c;
        case (b)
            CMD_RED:   c = COL_R;
            CMD_GREEN: c = COL_G;
            CMD_BLUE:  c = COL_B;
            default:   c = COL_OFF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO between the UART receiver and the command parser.
// A push into a full FIFO is kept only when a pop frees a slot in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic       ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_pop;
    logic          do_push;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers are AW bits wide, so wrap modulo DEPTH is free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !do_push) ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/rgb_cmd_ctrl.sv
// UART command parser driving one PWM-dimmed RGB LED.
// Bytes queue in byte_fifo; the FSM decodes one command per two cycles.
module rgb_cmd_ctrl
    import rgb_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ARG_TIMEOUT = 1_250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic       ld6r,
    output logic       ld6g,
    output logic       ld6b,
    output logic       cmd_err,
    output logic       fifo_ovf
);

    localparam int TMR_W = (ARG_TIMEOUT > 2) ? $clog2(ARG_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ARG_TIMEOUT - 1);

    state_t      state, state_nxt;
    color_t      color_q, color_nxt;
    logic [7:0]  cmd_q;
    logic [7:0]  duty_q;
    logic [7:0]  pwm_cnt;
    logic [TMR_W-1:0] tmr_q;

    logic       fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_dout;
    logic       cmd_ld, duty_ld, color_ld, err_nxt, tmr_clr, tmr_inc;
    logic       pwm_on;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid && !rx_err),
        .pop   (fifo_pop),
        .din   (rx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .ovf   (fifo_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (!fifo_empty) state_nxt = ST_DECODE;
            ST_DECODE:   state_nxt = (cmd_q == CMD_INT) ? ST_ARG_WAIT : ST_IDLE;
            ST_ARG_WAIT: if (!fifo_empty || tmr_q == TMR_LAST) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop  = 1'b0;
        cmd_ld    = 1'b0;
        duty_ld   = 1'b0;
        color_ld  = 1'b0;
        color_nxt = color_q;
        err_nxt   = 1'b0;
        tmr_clr   = 1'b0;
        tmr_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_ld   = 1'b1;
                end
            end
            ST_DECODE: begin
                if (is_color_cmd(cmd_q)) begin
                    color_ld  = 1'b1;
                    color_nxt = cmd_color(cmd_q);
                end else if (cmd_q == CMD_INT) begin
                    tmr_clr = 1'b1;
                end else begin
                    err_nxt = 1'b1;
                end
            end
            ST_ARG_WAIT: begin
                // An argument that arrives on the timeout cycle still wins.
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    duty_ld  = 1'b1;
                end else if (tmr_q == TMR_LAST) begin
                    err_nxt = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q   <= '0;
            color_q <= COL_OFF;
            duty_q  <= DUTY_RESET;
            tmr_q   <= '0;
            cmd_err <= 1'b0;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            cmd_err <= err_nxt;
            if (cmd_ld)   cmd_q   <= fifo_dout;
            if (color_ld) color_q <= color_nxt;
            if (duty_ld)  duty_q  <= fifo_dout;
            if (tmr_clr)      tmr_q <= '0;
            else if (tmr_inc) tmr_q <= tmr_q + 1'b1;
        end
    end

    // Only one color select can be active, so at most one LED lights.
    assign pwm_on = (pwm_cnt < duty_q);
    assign ld6r   = pwm_on && (color_q == COL_R);
    assign ld6g   = pwm_on && (color_q == COL_G);
    assign ld6b   = pwm_on && (color_q == COL_B);

endmodule

// File: tb/tb_rgb_cmd_ctrl.sv
// Self-checking bench for rgb_cmd_ctrl: LED duty measurement plus a
// scoreboard of expected cmd_err pulse cycles.
module tb_rgb_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_err = 1'b0;
    logic       ld6r, ld6g, ld6b, cmd_err, fifo_ovf;

    int checks = 0;
    int errors = 0;
    int cyc;
    int multi = 0;
    int exp_q[$];

    rgb_cmd_ctrl #(.FIFO_DEPTH(4), .ARG_TIMEOUT(100)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .ld6r     (ld6r),
        .ld6g     (ld6g),
        .ld6b     (ld6b),
        .cmd_err  (cmd_err),
        .fifo_ovf (fifo_ovf)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the PWM counter must track this mod 256.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (int'(ld6r) + int'(ld6g) + int'(ld6b) > 1) multi++;
    end

    // cmd_err scoreboard: each pulse must match the next expected cycle.
    always @(negedge clk) begin
        if (rst && cmd_err) begin
            int e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cmd_err_unexpected at cyc %0d, none expected", cyc);
            end else begin
                e = exp_q.pop_front();
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL cmd_err_cycle got %0d expected %0d", cyc, e);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic e, output int c);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        rx_err   = e;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        c = cyc;
    endtask

    task automatic measure(input int er, input int eg, input int eb, input string nm);
        int nr = 0, ng = 0, nb = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            nr += int'(ld6r);
            ng += int'(ld6g);
            nb += int'(ld6b);
        end
        checks += 3;
        if (nr !== er) begin errors++; $display("FAIL %s ld6r high %0d expected %0d", nm, nr, er); end
        if (ng !== eg) begin errors++; $display("FAIL %s ld6g high %0d expected %0d", nm, ng, eg); end
        if (nb !== eb) begin errors++; $display("FAIL %s ld6b high %0d expected %0d", nm, nb, eb); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (ld6r !== 1'b0)     begin errors++; $display("FAIL reset_ld6r got %b expected 0", ld6r); end
        if (ld6g !== 1'b0)     begin errors++; $display("FAIL reset_ld6g got %b expected 0", ld6g); end
        if (ld6b !== 1'b0)     begin errors++; $display("FAIL reset_ld6b got %b expected 0", ld6b); end
        if (cmd_err !== 1'b0)  begin errors++; $display("FAIL reset_cmd_err got %b expected 0", cmd_err); end
        if (fifo_ovf !== 1'b0) begin errors++; $display("FAIL reset_fifo_ovf got %b expected 0", fifo_ovf); end
        rst = 1'b1;
    endtask

    task automatic test_color_r();
        int c;
        send(8'h72, 1'b0, c);
        @(negedge clk);
        checks++;
        if (ld6r !== 1'b0) begin errors++; $display("FAIL latency_early ld6r got %b expected 0", ld6r); end
        @(negedge clk);
        checks++;
        if (ld6r !== ((cyc % 256) < 255)) begin
            errors++; $display("FAIL latency_apply ld6r got %b expected %b", ld6r, (cyc % 256) < 255);
        end
        repeat (3) @(negedge clk);
        measure(255, 0, 0, "color_r");
    endtask

    task automatic test_duty();
        int c;
        send(8'h69, 1'b0, c);
        repeat (10) @(negedge clk);
        send(8'h40, 1'b0, c);
        send(8'h67, 1'b0, c);
        repeat (4) @(negedge clk);
        measure(0, 64, 0, "duty_40_g");
    endtask

    task automatic test_timeout();
        int c;
        send(8'h69, 1'b0, c);
        exp_q.push_back(c + 102);
        repeat (110) @(negedge clk);
        measure(0, 64, 0, "timeout_keep_duty");
    endtask

    task automatic test_bad_cmd();
        int c;
        send(8'h41, 1'b0, c);
        exp_q.push_back(c + 2);
        repeat (4) @(negedge clk);
        measure(0, 64, 0, "bad_cmd_keep_color");
        send(8'h72, 1'b1, c);
        repeat (4) @(negedge clk);
        measure(0, 64, 0, "rx_err_ignored");
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [10] = '{8'h72, 8'h67, 8'h62, 8'h6F, 8'h72, 8'h67,
                                 8'h41, 8'h72, 8'h41, 8'h62};
        int c0;
        checks++;
        if (fifo_ovf !== 1'b0) begin errors++; $display("FAIL ovf_before_burst got %b expected 0", fifo_ovf); end
        @(negedge clk);
        c0 = cyc + 1;
        // One pop every two cycles: byte 6 decodes 14 edges after the first push,
        // and byte 8 hits a full FIFO with no pop and is dropped.
        exp_q.push_back(c0 + 14);
        for (int k = 0; k < 10; k++) begin
            rx_data  = seq[k];
            rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        repeat (24) @(negedge clk);
        checks++;
        if (fifo_ovf !== 1'b1) begin errors++; $display("FAIL ovf_after_burst got %b expected 1", fifo_ovf); end
        measure(0, 0, 64, "burst_final_b");
    endtask

    task automatic test_reset_mid();
        int c;
        @(negedge clk);
        rx_data = 8'h69; rx_valid = 1'b1;
        @(negedge clk);
        rx_data = 8'h10;
        @(negedge clk);
        rx_data = 8'h67;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks += 5;
        if (ld6r !== 1'b0)     begin errors++; $display("FAIL midrst_ld6r got %b expected 0", ld6r); end
        if (ld6g !== 1'b0)     begin errors++; $display("FAIL midrst_ld6g got %b expected 0", ld6g); end
        if (ld6b !== 1'b0)     begin errors++; $display("FAIL midrst_ld6b got %b expected 0", ld6b); end
        if (cmd_err !== 1'b0)  begin errors++; $display("FAIL midrst_cmd_err got %b expected 0", cmd_err); end
        if (fifo_ovf !== 1'b0) begin errors++; $display("FAIL midrst_fifo_ovf got %b expected 0", fifo_ovf); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        measure(0, 0, 0, "after_rst_off");
        send(8'h72, 1'b0, c);
        repeat (4) @(negedge clk);
        measure(255, 0, 0, "after_rst_duty_ff");
    endtask

    initial begin
        test_reset();
        test_color_r();
        test_duty();
        test_timeout();
        test_bad_cmd();
        test_back_to_back();
        test_reset_mid();
        repeat (4) @(negedge clk);
        checks += 2;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL cmd_err_missing pending %0d expected 0", exp_q.size());
        end
        if (multi !== 0) begin
            errors++; $display("FAIL led_onehot multi-lit cycles %0d expected 0", multi);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
